// File: rtl/pipe_result_collector.sv
// Collects results of a fixed-latency, non-stallable adder chain into an in-order FWFT FIFO.
// Issue is credit-gated so every in-flight result is guaranteed a FIFO slot.
module pipe_result_collector #(
  parameter int unsigned W     = 32,
  parameter int unsigned LAT   = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [W-1:0]               pipe_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [W-1:0]               res_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LAT-1:0] r_sr;
  logic [W-1:0]   r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  r_credits;
  logic           r_res_valid;
  logic [W-1:0]   r_res_data;
  logic           r_issue_ready;
  logic           r_overflow;

  logic           w_issue;
  logic           w_pop;
  logic           w_push;
  logic           w_full;
  logic           w_wr_en;
  logic           w_ovf;
  logic [LAT-1:0] w_sr_nxt;
  logic [PW-1:0]  w_wr_ptr_nxt;
  logic [PW-1:0]  w_rd_ptr_nxt;
  logic [CW-1:0]  w_count_nxt;
  logic [CW-1:0]  w_credits_nxt;
  logic [W-1:0]   w_head_nxt;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshakes and next-state for tags, pointers, occupancy and credits
  always_comb begin
    w_issue       = issue_valid & r_issue_ready;
    w_pop         = r_res_valid & res_ready;
    w_push        = r_sr[LAT-1];
    w_full        = (r_count == CW'(DEPTH));
    w_wr_en       = w_push & (~w_full | w_pop);
    w_ovf         = w_push & w_full & ~w_pop;
    w_sr_nxt      = (r_sr << 1) | LAT'(w_issue);
    w_wr_ptr_nxt  = w_wr_en ? f_inc(r_wr_ptr) : r_wr_ptr;
    w_rd_ptr_nxt  = w_pop ? f_inc(r_rd_ptr) : r_rd_ptr;
    w_count_nxt   = r_count;
    w_credits_nxt = r_credits;
    if (w_wr_en && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_wr_en && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
    if (w_issue && !w_pop) begin
      w_credits_nxt = r_credits - CW'(1);
    end else if (!w_issue && w_pop) begin
      w_credits_nxt = r_credits + CW'(1);
    end
  end

  // Next head word; bypasses the incoming result when it lands at the new head
  always_comb begin
    w_head_nxt = '0;
    if (w_count_nxt != '0) begin
      if (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) begin
        w_head_nxt = pipe_out;
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= pipe_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr          <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_credits     <= CW'(DEPTH);
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_issue_ready <= 1'b1;
      r_overflow    <= 1'b0;
    end else begin
      r_sr          <= w_sr_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_count       <= w_count_nxt;
      r_credits     <= w_credits_nxt;
      r_res_valid   <= (w_count_nxt != '0);
      r_res_data    <= w_head_nxt;
      r_issue_ready <= (w_credits_nxt != '0);
      r_overflow    <= r_overflow | w_ovf;
    end
  end

  assign issue_ready = r_issue_ready;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign count       = r_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed bench for pipe_result_collector: reset, latency, credit stall, near-full push/pop,
// streaming with pointer wrap, and asynchronous reset with results in flight.
module tb_pipe_result_collector;

  localparam int unsigned W     = 32;
  localparam int unsigned LAT   = 10;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          issue_valid;
  logic          issue_ready;
  logic [W-1:0]  pipe_out;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic [CW-1:0] count;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  int accepted = 0;
  logic [31:0] exp_drain [16];

  pipe_result_collector #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .pipe_out    (pipe_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .count       (count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b0;
    issue_valid = 1'b0;
    pipe_out    = '0;
    res_ready   = 1'b0;

    // Reset held for 3 cycles
    step(3);
    chk("rst_low_valid", 32'(res_valid), 32'd0);
    chk("rst_low_count", 32'(count), 32'd0);
    rst = 1'b1;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Single token: result appears LAT+1 cycles after issue
    issue_valid = 1'b1;
    step(1);
    issue_valid = 1'b0;
    step(9);
    pipe_out = 32'h0000_1234;
    chk("single_c10_valid", 32'(res_valid), 32'd0);
    step(1);
    pipe_out = '0;
    chk("single_c11_valid", 32'(res_valid), 32'd1);
    chk("single_c11_data", res_data, 32'h0000_1234);
    chk("single_c11_count", 32'(count), 32'd1);
    step(1);
    chk("single_c12_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    chk("single_c13_valid", 32'(res_valid), 32'd0);
    chk("single_c13_count", 32'(count), 32'd0);
    chk("single_c13_data", res_data, 32'd0);

    // Credit stall, then near-full push/pop boundary and drain
    for (int j = 0; j < 14; j++) exp_drain[j] = 32'hA00C + 32'(j);
    exp_drain[14] = 32'hA029;
    exp_drain[15] = 32'hA034;
    accepted = 0;
    for (int k = 0; k < 70; k++) begin
      pipe_out    = 32'hA000 + 32'(k);
      issue_valid = (k != 43) && (k < 44);
      res_ready   = (k == 30) || (k == 41) || (k >= 53 && k < 69);
      if (k == 15) chk("stall_c15_ready", 32'(issue_ready), 32'd1);
      if (k == 16) chk("stall_c16_ready", 32'(issue_ready), 32'd0);
      if (k == 30) begin
        chk("stall_accepted16", 32'(accepted), 32'd16);
        chk("stall_full_count", 32'(count), 32'd16);
        chk("stall_head", res_data, 32'hA00A);
        chk("stall_full_ready", 32'(issue_ready), 32'd0);
        chk("stall_full_ovf", 32'(overflow), 32'd0);
      end
      if (k == 31) begin
        chk("credit_ret_ready", 32'(issue_ready), 32'd1);
        chk("credit_ret_count", 32'(count), 32'd15);
        chk("credit_ret_head", res_data, 32'hA00B);
      end
      if (k == 32) chk("credit_used_ready", 32'(issue_ready), 32'd0);
      if (k == 41) chk("pushpop_c41_count", 32'(count), 32'd15);
      if (k == 42) begin
        chk("pushpop_c42_count", 32'(count), 32'd15);
        chk("pushpop_c42_head", res_data, 32'hA00C);
        chk("pushpop_c42_ready", 32'(issue_ready), 32'd1);
      end
      if (k == 43) chk("pushpop_c43_ready", 32'(issue_ready), 32'd0);
      if (k == 53) begin
        chk("refill_count16", 32'(count), 32'd16);
        chk("refill_ovf", 32'(overflow), 32'd0);
        chk("accepted18", 32'(accepted), 32'd18);
      end
      if (k >= 53 && k < 69) begin
        chk($sformatf("drain_%0d", k - 53), res_data, exp_drain[k-53]);
      end
      if (k == 69) begin
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_valid", 32'(res_valid), 32'd0);
        chk("drain_ready", 32'(issue_ready), 32'd1);
      end
      if (issue_valid && issue_ready) accepted++;
      step(1);
    end
    issue_valid = 1'b0;
    res_ready   = 1'b0;
    pipe_out    = '0;

    // Streaming 40 back-to-back tokens with consumer always ready
    accepted  = 0;
    res_ready = 1'b1;
    for (int k = 0; k < 53; k++) begin
      issue_valid = (k < 40);
      pipe_out    = (k >= 10 && k < 50) ? 32'(k - 9) : 32'd0;
      if (k < 40) chk($sformatf("stream_ready_%0d", k), 32'(issue_ready), 32'd1);
      if (k >= 11 && k <= 50) begin
        chk($sformatf("stream_valid_%0d", k), 32'(res_valid), 32'd1);
        chk($sformatf("stream_data_%0d", k), res_data, 32'(k - 10));
      end
      if (k == 10) chk("stream_c10_valid", 32'(res_valid), 32'd0);
      if (k == 51) chk("stream_c51_valid", 32'(res_valid), 32'd0);
      if (issue_valid && issue_ready) accepted++;
      step(1);
    end
    chk("stream_accepted", 32'(accepted), 32'd40);
    chk("stream_ovf", 32'(overflow), 32'd0);
    issue_valid = 1'b0;
    res_ready   = 1'b0;

    // Asynchronous reset with 3 stored results and 5 in flight
    for (int k = 0; k < 13; k++) begin
      issue_valid = (k < 8);
      pipe_out    = 32'hB000 + 32'(k);
      step(1);
    end
    issue_valid = 1'b0;
    chk("async_pre_count", 32'(count), 32'd3);
    chk("async_pre_head", res_data, 32'hB00A);
    #3;
    rst = 1'b0;
    #1;
    chk("async_valid", 32'(res_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_data", res_data, 32'd0);
    chk("async_ready", 32'(issue_ready), 32'd1);
    step(1);
    rst      = 1'b1;
    pipe_out = 32'hDEAD_BEEF;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("no_stale_%0d", k), 32'(res_valid), 32'd0);
      step(1);
    end
    chk("post_rst_count", 32'(count), 32'd0);
    issue_valid = 1'b1;
    step(1);
    issue_valid = 1'b0;
    step(9);
    pipe_out = 32'h0000_C0DE;
    chk("post_rst_c10_valid", 32'(res_valid), 32'd0);
    step(1);
    pipe_out = '0;
    chk("post_rst_c11_valid", 32'(res_valid), 32'd1);
    chk("post_rst_c11_data", res_data, 32'h0000_C0DE);
    chk("final_ovf", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
